// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter sequencer and its return stack.
package pc_pkg;

  typedef enum logic [2:0] {
    OP_INC  = 3'd0,
    OP_JMP  = 3'd1,
    OP_BRA  = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4
  } pc_op_e;

  // Sequential step: leaving the wrap limit returns to the reset address, otherwise +1 modulo 2**aw.
  function automatic logic [31:0] pc_seq(input logic [31:0] pc,
                                         input logic [31:0] limit,
                                         input logic [31:0] rst_addr,
                                         input int unsigned aw);
    logic [31:0] mask;
    mask = (32'd1 << aw) - 32'd1;
    return (pc == limit) ? rst_addr : ((pc + 32'd1) & mask);
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO: one push or one pop per cycle, registered empty/full flags.
module pc_ret_stack
  import pc_pkg::*;
#(
  parameter int AW    = 6,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] dout,
  output logic          empty,
  output logic          full
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]  mem [DEPTH];
  logic [SPW-1:0] sp;
  logic [SPW-1:0] sp_next;
  logic           do_push;
  logic           do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !push && !empty;
  assign dout    = mem[IW'(sp - SPW'(1))];

  always_comb begin
    sp_next = sp;
    if (do_push) begin
      sp_next = sp + SPW'(1);
    end else if (do_pop) begin
      sp_next = sp - SPW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp    <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      sp    <= sp_next;
      empty <= (sp_next == '0);
      full  <= (sp_next == SPW'(DEPTH));
    end
  end

  // Storage is deliberately left out of reset; only the pointer defines what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && do_push) begin
      mem[IW'(sp)] <= din;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: step/jump/branch/call/return with programmable wrap limit.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int AW          = 6,
  parameter int STACK_DEPTH = 4,
  parameter int WRAP_LIMIT  = 2**AW - 1,
  parameter int RESET_ADDR  = 0
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          EN,
  input  logic [2:0]    OP,
  input  logic [AW-1:0] TARGET,
  input  logic [AW-1:0] OFFSET,
  input  logic          ERR_CLR,
  output logic [AW-1:0] PC_OUT,
  output logic          WRAP,
  output logic          STK_EMPTY,
  output logic          STK_FULL,
  output logic          STK_ERR
);

  localparam logic [AW-1:0] LIMIT  = AW'(WRAP_LIMIT);
  localparam logic [AW-1:0] RST_PC = AW'(RESET_ADDR);

  logic [AW-1:0] pc;
  logic [AW-1:0] seq_pc;
  logic [AW-1:0] tgt;
  logic [AW-1:0] nxt_pc;
  logic [AW-1:0] top;
  logic          nxt_wrap;
  logic          use_tgt;
  logic          step;
  logic          push;
  logic          pop;
  logic          err_set;

  assign seq_pc = AW'(pc_seq(32'(pc), 32'(WRAP_LIMIT), 32'(RESET_ADDR), AW));
  assign PC_OUT = pc;

  pc_ret_stack #(
    .AW    (AW),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (push),
    .pop   (pop),
    .din   (seq_pc),
    .dout  (top),
    .empty (STK_EMPTY),
    .full  (STK_FULL)
  );

  // Stack overflow/underflow degrades to a plain step; out-of-range targets fall back to the reset address.
  always_comb begin
    nxt_pc   = pc;
    nxt_wrap = 1'b0;
    tgt      = TARGET;
    use_tgt  = 1'b0;
    step     = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    err_set  = 1'b0;
    if (EN) begin
      case (pc_op_e'(OP))
        OP_JMP: use_tgt = 1'b1;
        OP_BRA: begin
          tgt     = pc + OFFSET;
          use_tgt = 1'b1;
        end
        OP_CALL: begin
          if (!STK_FULL) begin
            push    = 1'b1;
            use_tgt = 1'b1;
          end else begin
            step    = 1'b1;
            err_set = 1'b1;
          end
        end
        OP_RET: begin
          if (!STK_EMPTY) begin
            pop    = 1'b1;
            nxt_pc = top;
          end else begin
            step    = 1'b1;
            err_set = 1'b1;
          end
        end
        default: step = 1'b1;
      endcase
      if (step) begin
        nxt_pc   = seq_pc;
        nxt_wrap = (pc == LIMIT);
      end
      if (use_tgt) begin
        if (tgt > LIMIT) begin
          nxt_pc   = RST_PC;
          nxt_wrap = 1'b1;
        end else begin
          nxt_pc = tgt;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pc      <= RST_PC;
      WRAP    <= 1'b0;
      STK_ERR <= 1'b0;
    end else begin
      pc   <= nxt_pc;
      WRAP <= nxt_wrap;
      if (err_set) begin
        STK_ERR <= 1'b1;
      end else if (ERR_CLR) begin
        STK_ERR <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Three sequencer configurations driven in lockstep and checked against a behavioural model.
module tb_pc_sequencer;
  import pc_pkg::*;

  localparam int NI = 3;
  localparam int LIM [NI] = '{63, 9, 31};
  localparam int RA  [NI] = '{0, 2, 0};

  logic       clk;
  logic       rstN;
  logic       en;
  logic [2:0] op;
  logic [5:0] target;
  logic [5:0] offset;
  logic       errClr;

  logic [5:0] pcOut    [NI];
  logic       wrapOut  [NI];
  logic       emptyOut [NI];
  logic       fullOut  [NI];
  logic       errOut   [NI];

  int mPc   [NI];
  int mCnt  [NI];
  int mStk  [NI][4];
  int mErr  [NI];
  int mWrap [NI];

  int errors = 0;
  int checks = 0;

  pc_sequencer #(.AW(6), .STACK_DEPTH(4)) dut0 (
    .CLK(clk), .RST_N(rstN), .EN(en), .OP(op), .TARGET(target), .OFFSET(offset),
    .ERR_CLR(errClr), .PC_OUT(pcOut[0]), .WRAP(wrapOut[0]), .STK_EMPTY(emptyOut[0]),
    .STK_FULL(fullOut[0]), .STK_ERR(errOut[0]));

  pc_sequencer #(.AW(6), .STACK_DEPTH(4), .WRAP_LIMIT(9), .RESET_ADDR(2)) dut1 (
    .CLK(clk), .RST_N(rstN), .EN(en), .OP(op), .TARGET(target), .OFFSET(offset),
    .ERR_CLR(errClr), .PC_OUT(pcOut[1]), .WRAP(wrapOut[1]), .STK_EMPTY(emptyOut[1]),
    .STK_FULL(fullOut[1]), .STK_ERR(errOut[1]));

  pc_sequencer #(.AW(6), .STACK_DEPTH(4), .WRAP_LIMIT(31)) dut2 (
    .CLK(clk), .RST_N(rstN), .EN(en), .OP(op), .TARGET(target), .OFFSET(offset),
    .ERR_CLR(errClr), .PC_OUT(pcOut[2]), .WRAP(wrapOut[2]), .STK_EMPTY(emptyOut[2]),
    .STK_FULL(fullOut[2]), .STK_ERR(errOut[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int seqOf(input int i, input int pc);
    return (pc == LIM[i]) ? RA[i] : (pc + 1) % 64;
  endfunction

  // Reference behaviour: integer PC, array-backed return stack, plain arithmetic on addresses.
  task automatic modelStep(input int i);
    int  tgt;
    int  off;
    bit  w;
    bit  e;
    bit  goTgt;
    bit  inc;
    if (!rstN) begin
      mPc[i] = RA[i]; mCnt[i] = 0; mErr[i] = 0; mWrap[i] = 0;
      return;
    end
    w = 0; e = 0; goTgt = 0; inc = 0; tgt = 0;
    if (en) begin
      case (int'(op))
        1: begin goTgt = 1; tgt = int'(target); end
        2: begin
          off   = (int'(offset) >= 32) ? int'(offset) - 64 : int'(offset);
          tgt   = ((mPc[i] + off) % 64 + 64) % 64;
          goTgt = 1;
        end
        3: begin
          if (mCnt[i] < 4) begin
            mStk[i][mCnt[i]] = seqOf(i, mPc[i]);
            mCnt[i]++;
            goTgt = 1;
            tgt   = int'(target);
          end else begin
            inc = 1; e = 1;
          end
        end
        4: begin
          if (mCnt[i] > 0) begin
            mCnt[i]--;
            mPc[i] = mStk[i][mCnt[i]];
          end else begin
            inc = 1; e = 1;
          end
        end
        default: inc = 1;
      endcase
    end
    if (inc) begin
      w      = (mPc[i] == LIM[i]);
      mPc[i] = seqOf(i, mPc[i]);
    end
    if (goTgt) begin
      if (tgt > LIM[i]) begin
        mPc[i] = RA[i];
        w      = 1;
      end else begin
        mPc[i] = tgt;
      end
    end
    mWrap[i] = w;
    if (e) mErr[i] = 1;
    else if (errClr) mErr[i] = 0;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [2:0] o,
                               input logic [5:0] t, input logic [5:0] f, input logic c);
    rstN = r; en = e; op = o; target = t; offset = f; errClr = c;
    @(posedge clk);
    for (int i = 0; i < NI; i++) modelStep(i);
    #1;
  endtask

  task automatic checkOutput();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("pc%0d", i),    int'(pcOut[i]),    mPc[i]);
      check($sformatf("wrap%0d", i),  int'(wrapOut[i]),  mWrap[i]);
      check($sformatf("empty%0d", i), int'(emptyOut[i]), int'(mCnt[i] == 0));
      check($sformatf("full%0d", i),  int'(fullOut[i]),  int'(mCnt[i] == 4));
      check($sformatf("err%0d", i),   int'(errOut[i]),   mErr[i]);
    end
  endtask

  task automatic step(input logic [2:0] o, input logic [5:0] t = 6'd0,
                      input logic [5:0] f = 6'd0, input logic c = 1'b0);
    applyStimulus(1'b1, 1'b1, o, t, f, c);
    checkOutput();
  endtask

  initial begin
    rstN = 1'b0; en = 1'b1; op = OP_INC; target = '0; offset = '0; errClr = 1'b0;

    // Reset held two cycles while an INC is requested
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 1'b1, OP_INC, 6'd0, 6'd0, 1'b0);
      checkOutput();
      check("rst_pc0", int'(pcOut[0]), 0);
      check("rst_pc1", int'(pcOut[1]), 2);
      check("rst_empty", int'(emptyOut[0]), 1);
      check("rst_err", int'(errOut[0]), 0);
    end

    // Full count through the wrap point
    for (int k = 0; k < 64; k++) begin
      step(OP_INC);
      if (k == 7) begin
        check("lim9_pc", int'(pcOut[1]), 2);
        check("lim9_wrap", int'(wrapOut[1]), 1);
      end
      if (k == 62) begin
        check("cnt_pc63", int'(pcOut[0]), 63);
        check("cnt_nowrap", int'(wrapOut[0]), 0);
      end
    end
    check("wrap_pc0", int'(pcOut[0]), 0);
    check("wrap_pulse", int'(wrapOut[0]), 1);

    for (int k = 0; k < 5; k++) step(OP_INC);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, OP_JMP, 6'd33, 6'd0, 1'b0);
      checkOutput();
    end
    check("stall_pc", int'(pcOut[0]), 5);
    check("stall_wrap", int'(wrapOut[0]), 0);

    // Jumps and branches
    step(OP_JMP, 6'd10);
    step(OP_BRA, 6'd0, 6'h3E);
    check("bra_back", int'(pcOut[0]), 8);
    step(OP_JMP, 6'd60);
    step(OP_BRA, 6'd0, 6'd7);
    check("bra_fwd", int'(pcOut[0]), 3);
    check("bra_nowrap", int'(wrapOut[0]), 0);
    step(OP_JMP, 6'd40);
    check("jmp_pc", int'(pcOut[0]), 40);
    check("jmp_illegal_pc", int'(pcOut[2]), 0);
    check("jmp_illegal_wrap", int'(wrapOut[2]), 1);

    // Nested call and return
    step(OP_JMP, 6'd5);
    step(OP_CALL, 6'd20);
    check("call1", int'(pcOut[0]), 20);
    step(OP_INC);
    step(OP_CALL, 6'd30);
    check("call2", int'(pcOut[0]), 30);
    step(OP_RET);
    check("ret1", int'(pcOut[0]), 22);
    step(OP_RET);
    check("ret2", int'(pcOut[0]), 6);
    check("ret_empty", int'(emptyOut[0]), 1);

    // Overflow, underflow and error clear priority
    for (int k = 0; k < 4; k++) step(OP_CALL, 6'(10 + k));
    check("full_flag", int'(fullOut[0]), 1);
    step(OP_CALL, 6'd50);
    check("ovf_pc", int'(pcOut[0]), 14);
    check("ovf_err", int'(errOut[0]), 1);
    step(OP_INC, 6'd0, 6'd0, 1'b1);
    check("clr_err", int'(errOut[0]), 0);
    for (int k = 0; k < 4; k++) step(OP_RET);
    check("unwind_pc", int'(pcOut[0]), 7);
    step(OP_RET);
    check("udf_pc", int'(pcOut[0]), 8);
    check("udf_err", int'(errOut[0]), 1);
    step(OP_RET, 6'd0, 6'd0, 1'b1);
    check("set_beats_clr", int'(errOut[0]), 1);
    step(OP_INC, 6'd0, 6'd0, 1'b1);
    check("clr_again", int'(errOut[0]), 0);

    // Reset arriving together with a CALL
    step(OP_CALL, 6'd30);
    step(OP_CALL, 6'd40);
    applyStimulus(1'b0, 1'b1, OP_CALL, 6'd50, 6'd0, 1'b0);
    checkOutput();
    check("rstcall_pc", int'(pcOut[0]), 0);
    check("rstcall_empty", int'(emptyOut[0]), 1);
    step(OP_RET);
    check("rstcall_nopop", int'(pcOut[0]), 1);
    check("rstcall_err", int'(errOut[0]), 1);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      applyStimulus(($urandom_range(0, 49) != 0), ($urandom_range(0, 4) != 0),
                    3'($urandom_range(0, 7)), 6'($urandom_range(0, 63)),
                    6'($urandom_range(0, 63)), ($urandom_range(0, 9) == 0));
      checkOutput();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
